// File: rtl/alarm_pkg.sv
// Shared types and constants for the alarm sequencer.
// Holds the FSM state encoding, the level limits, the default key
// make codes and the countdown width.
package alarm_pkg;

  localparam int unsigned CNT_W   = 8;
  localparam int unsigned CNT_MAX = 255;
  localparam int unsigned LVL_W   = 2;
  localparam int unsigned MODE_W  = 3;

  // Encodings are visible on the mode output; 5..7 are illegal.
  typedef enum logic [MODE_W-1:0] {
    S_DISARMED = 3'd0,
    S_EXIT     = 3'd1,
    S_ARMED    = 3'd2,
    S_ENTRY    = 3'd3,
    S_ALARM    = 3'd4
  } state_t;

  localparam logic [LVL_W-1:0] LVL_MIN = 2'd0;
  localparam logic [LVL_W-1:0] LVL_MAX = 2'd2;

  localparam logic [7:0] KEY_LEFT_DEF   = 8'h6B;
  localparam logic [7:0] KEY_RIGHT_DEF  = 8'h74;
  localparam logic [7:0] KEY_ARM_DEF    = 8'h5A;
  localparam logic [7:0] KEY_DISARM_DEF = 8'h76;

endpackage

// File: rtl/alarm_delay_timer.sv
// Loadable down-counter paced by a tick enable.
// Ports: clk, rst_n (async, active-low); tick advances the count;
// load/load_val preload; clr zeroes (clr > load > tick); count is the
// registered remaining value; expire_c pulses on the tick taking 1 -> 0.
module alarm_delay_timer
  import alarm_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             clr,
  output logic [CNT_W-1:0] count,
  output logic             expire_c
);

  // Counter register; holds at zero between delays.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (tick && (count != '0)) begin
      count <= count - CNT_W'(1);
    end
  end

  // Expiry is the last tick of a loaded delay.
  assign expire_c = tick && (count == CNT_W'(1));

endmodule

// File: rtl/alarm_sequencer.sv
// Alarm arm / exit-delay / entry-delay / siren controller.
// Ports: clk, rst_n (async, active-low); tick 1 Hz enable; key_valid and
// key_code decoded make codes; sensor_trip intrusion level input.
// Outputs (all registered): level 0..2, mode (state code), armed, siren,
// chirp (toggles per tick during delays), countdown (active delay ticks).
module alarm_sequencer
  import alarm_pkg::*;
#(
  parameter logic [7:0]  KEY_LEFT    = KEY_LEFT_DEF,
  parameter logic [7:0]  KEY_RIGHT   = KEY_RIGHT_DEF,
  parameter logic [7:0]  KEY_ARM     = KEY_ARM_DEF,
  parameter logic [7:0]  KEY_DISARM  = KEY_DISARM_DEF,
  parameter int unsigned EXIT_TICKS  = 10,
  parameter int unsigned ENTRY_L0    = 20,
  parameter int unsigned ENTRY_L1    = 5,
  parameter int unsigned SIREN_TICKS = 30
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tick,
  input  logic              key_valid,
  input  logic [7:0]        key_code,
  input  logic              sensor_trip,
  output logic [LVL_W-1:0]  level,
  output logic [MODE_W-1:0] mode,
  output logic              armed,
  output logic              siren,
  output logic              chirp,
  output logic [CNT_W-1:0]  countdown
);

  // Delays must fit the 8-bit countdown.
  if ((EXIT_TICKS > CNT_MAX) || (ENTRY_L0 > CNT_MAX) ||
      (ENTRY_L1 > CNT_MAX) || (SIREN_TICKS > CNT_MAX)) begin : g_param_range
    $error("alarm_sequencer: delay parameters exceed %0d", CNT_MAX);
  end

  state_t             state, state_n;
  logic [LVL_W-1:0]   level_n;
  logic               chirp_n;
  logic               tmr_load_c, tmr_clr_c, expire_c;
  logic [CNT_W-1:0]   tmr_val_c, entry_delay_c;
  logic               key_left_c, key_right_c, key_arm_c, key_disarm_c;

  assign key_left_c   = key_valid && (key_code == KEY_LEFT);
  assign key_right_c  = key_valid && (key_code == KEY_RIGHT);
  assign key_arm_c    = key_valid && (key_code == KEY_ARM);
  assign key_disarm_c = key_valid && (key_code == KEY_DISARM);

  // Entry delay for the current level; zero means trip straight to siren.
  always_comb begin
    entry_delay_c = '0;
    case (level)
      2'd0:    entry_delay_c = CNT_W'(ENTRY_L0);
      2'd1:    entry_delay_c = CNT_W'(ENTRY_L1);
      default: entry_delay_c = '0;
    endcase
  end

  alarm_delay_timer u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .tick     (tick),
    .load     (tmr_load_c),
    .load_val (tmr_val_c),
    .clr      (tmr_clr_c),
    .count    (countdown),
    .expire_c (expire_c)
  );

  // Next state, level and timer commands; disarm outranks everything,
  // then sensor_trip, then tick, then the arm key.
  always_comb begin
    state_n    = state;
    level_n    = level;
    chirp_n    = 1'b0;
    tmr_load_c = 1'b0;
    tmr_clr_c  = 1'b0;
    tmr_val_c  = '0;
    if ((state != S_DISARMED) && key_disarm_c) begin
      state_n   = S_DISARMED;
      tmr_clr_c = 1'b1;
    end else begin
      case (state)
        S_DISARMED: begin
          if (key_left_c && (level < LVL_MAX)) begin
            level_n = level + 2'd1;
          end else if (key_right_c && (level > LVL_MIN)) begin
            level_n = level - 2'd1;
          end else if (key_arm_c) begin
            if (EXIT_TICKS != 0) begin
              state_n    = S_EXIT;
              tmr_load_c = 1'b1;
              tmr_val_c  = CNT_W'(EXIT_TICKS);
            end else begin
              state_n = S_ARMED;
            end
          end
        end
        S_EXIT: begin
          chirp_n = chirp ^ tick;
          if (expire_c) begin
            state_n = S_ARMED;
            chirp_n = 1'b0;
          end
        end
        S_ARMED: begin
          if (sensor_trip) begin
            tmr_load_c = 1'b1;
            if (entry_delay_c != '0) begin
              state_n   = S_ENTRY;
              tmr_val_c = entry_delay_c;
            end else begin
              state_n   = S_ALARM;
              tmr_val_c = CNT_W'(SIREN_TICKS);
            end
          end
        end
        S_ENTRY: begin
          chirp_n = chirp ^ tick;
          if (expire_c) begin
            state_n    = S_ALARM;
            chirp_n    = 1'b0;
            tmr_load_c = 1'b1;
            tmr_val_c  = CNT_W'(SIREN_TICKS);
          end
        end
        S_ALARM: begin
          if (expire_c) begin
            state_n = S_ARMED;
          end
        end
        default: begin
          state_n   = S_DISARMED;
          tmr_clr_c = 1'b1;
        end
      endcase
    end
  end

  // State and output registers; armed/siren follow the next state so they
  // change in the same cycle as mode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_DISARMED;
      level <= LVL_MIN;
      chirp <= 1'b0;
      armed <= 1'b0;
      siren <= 1'b0;
    end else begin
      state <= state_n;
      level <= level_n;
      chirp <= chirp_n;
      armed <= (state_n == S_ARMED) || (state_n == S_ENTRY) || (state_n == S_ALARM);
      siren <= (state_n == S_ALARM);
    end
  end

  assign mode = state;

endmodule

// File: doc/alarm_sequencer.md
Name: alarm_sequencer

Overview:
Clocked controller that sequences the alarm datapath. Consumes decoded keyboard make-code events, a sensor-trip input and a 1 Hz tick enable. Owns the 0..2 alarm level, previously adjusted by left/right keys, and runs the arm / exit-delay / entry-delay / siren sequence. Sits between the keyboard decoder and the LED/seven-segment/siren drivers.

Parameters:
KEY_LEFT, 8'h6B, make code that increments level
KEY_RIGHT, 8'h74, make code that decrements level
KEY_ARM, 8'h5A, make code that arms (Enter)
KEY_DISARM, 8'h76, make code that disarms (Esc)
EXIT_TICKS, 10, exit-delay length in ticks (0 = skip)
ENTRY_L0, 20, entry delay at level 0, in ticks
ENTRY_L1, 5, entry delay at level 1, in ticks (level 2 = immediate)
SIREN_TICKS, 30, siren duration in ticks before auto-rearm

Ports:
clk  in  1  system clock
rst_n  in  1  reset
tick  in  1  one-cycle 1 Hz enable pulse
key_valid  in  1  one-cycle strobe, key_code valid
key_code  in  8  decoded make code
sensor_trip  in  1  level-sensitive intrusion input
level  out  2  alarm level 0..2
mode  out  3  current FSM state encoding
armed  out  1  high in ARMED, ENTRY, ALARM
siren  out  1  high in ALARM only
chirp  out  1  toggles on each tick in EXIT and ENTRY, else 0
countdown  out  8  remaining ticks of the active delay, else 0

Behaviour:
- One clock, clk; reset is asynchronous and active-low (rst_n). All registers are on the clk rising edge, cleared by rst_n low.
- Reset values: level=0, mode=DISARMED, armed=0, siren=0, chirp=0, countdown=0.
- States, with mode encoding: DISARMED=0, EXIT=1, ARMED=2, ENTRY=3, ALARM=4. Codes 5..7 are unreachable and must recover to DISARMED on the next clock.
- Level adjustment:
  - Only in DISARMED, on key_valid.
  - KEY_LEFT increments level, saturating at 2.
  - KEY_RIGHT decrements level, saturating at 0.
  - Ignored in all other states.
- DISARMED + key_valid with KEY_ARM:
  - If EXIT_TICKS != 0: go to EXIT and load countdown=EXIT_TICKS.
  - Otherwise go straight to ARMED.
- EXIT:
  - Each tick decrements countdown.
  - A tick seen with countdown==1 goes to ARMED and sets countdown=0. N loaded gives exactly N ticks.
  - sensor_trip is ignored in EXIT.
- ARMED + sensor_trip high, sampled on clk:
  - Load entry delay per level: 0→ENTRY_L0, 1→ENTRY_L1. Go to ENTRY.
  - If level==2, or the selected delay is 0: go directly to ALARM.
- ENTRY: counts down as in EXIT. Expiry goes to ALARM.
- ALARM:
  - On entry: load countdown=SIREN_TICKS; siren=1.
  - On expiry: return to ARMED with siren=0. If sensor_trip is still high, re-enter ENTRY/ALARM on the next clock.
- Outputs are registered and change with mode in the same cycle; there is no extra latency.
- KEY_DISARM (key_valid) in any non-DISARMED state:
  - Go to DISARMED next clock; countdown=0, siren=0, chirp=0.
  - level is preserved.
- Simultaneous-event priority, highest first: disarm > sensor_trip > tick > arm key.
  - A disarm on the same cycle as an expiry tick wins.
  - A sensor_trip on the same cycle as the ARMED transition from EXIT is not acted on until the next cycle.
- Only the make-code events listed above have an effect; other key codes are ignored. key_valid with tick in the same cycle: both are processed per the priority order.
- countdown is 8-bit. Parameters above 255 are illegal and are checked by an elaboration assertion.
- rst_n asserted mid-sequence (any state) returns immediately to the reset values.

Decomposition:
- Package alarm_pkg:
  - state enum and its encodings;
  - level constants LVL_MIN=0, LVL_MAX=2;
  - default key-code constants.
- One natural sub-module, alarm_delay_timer: loadable 8-bit down-counter with tick enable, synchronous clear and a one-cycle expire output. The FSM loads, clears and watches expire.

Test Plan:
- Reset, then key_valid with 8'h6B ×4, then 8'h74 ×1: level goes 1,2,2,2 then 1. mode stays 0.
- Level 0: arm (8'h5A) → mode=1, countdown=10. After 10 ticks → mode=2, armed=1, chirp toggled on each of those ticks.
- Level 1, armed: sensor_trip → mode=3, countdown=5. 5 ticks → mode=4, siren=1, countdown=30. 30 ticks with sensor low → mode=2, siren=0.
- Level 2, armed: sensor_trip → mode=4 on the next clock, with no ENTRY. Send 8'h76 on the same cycle as a tick → mode=0, siren=0, countdown=0.
- In ENTRY at countdown=3: assert rst_n low asynchronously, between clocks → outputs clear to reset values before the next clk edge.
- In ARMED: send 8'h6B, and an unknown code 8'h1C → level unchanged, mode unchanged.
